// File: rtl/alu_exec.sv
// Execute-stage ALU: computes the data-processing result, owns NZCV, and holds
// one registered result behind a valid/ready handshake toward writeback.
module alu_exec #(
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned ALUAW   = 4,
   parameter int unsigned FLAGS_W = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [ALUAW-1:0]   alu_opcode,
   input  logic [FLAGS_W-1:0] should_set_cpsr,
   input  logic [DATA_W-1:0]  op_a,
   input  logic [DATA_W-1:0]  op_b,
   input  logic [3:0]         rd_in,
   input  logic               flush,
   input  logic               cpsr_load,
   input  logic [FLAGS_W-1:0] cpsr_load_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [DATA_W-1:0]  result,
   output logic [3:0]         rd_out,
   output logic               rd_wr_en,
   output logic [FLAGS_W-1:0] flags
);

   localparam logic [ALUAW-1:0] OpAnd = ALUAW'(4'h0);
   localparam logic [ALUAW-1:0] OpEor = ALUAW'(4'h1);
   localparam logic [ALUAW-1:0] OpSub = ALUAW'(4'h2);
   localparam logic [ALUAW-1:0] OpRsb = ALUAW'(4'h3);
   localparam logic [ALUAW-1:0] OpAdd = ALUAW'(4'h4);
   localparam logic [ALUAW-1:0] OpAdc = ALUAW'(4'h5);
   localparam logic [ALUAW-1:0] OpSbc = ALUAW'(4'h6);
   localparam logic [ALUAW-1:0] OpRsc = ALUAW'(4'h7);
   localparam logic [ALUAW-1:0] OpTst = ALUAW'(4'h8);
   localparam logic [ALUAW-1:0] OpTeq = ALUAW'(4'h9);
   localparam logic [ALUAW-1:0] OpCmp = ALUAW'(4'hA);
   localparam logic [ALUAW-1:0] OpCmn = ALUAW'(4'hB);
   localparam logic [ALUAW-1:0] OpOrr = ALUAW'(4'hC);
   localparam logic [ALUAW-1:0] OpMov = ALUAW'(4'hD);
   localparam logic [ALUAW-1:0] OpBic = ALUAW'(4'hE);
   localparam logic [ALUAW-1:0] OpMvn = ALUAW'(4'hF);

   localparam int unsigned FlagN = 3;
   localparam int unsigned FlagZ = 2;
   localparam int unsigned FlagC = 1;
   localparam int unsigned FlagV = 0;

   logic               out_valid_q;
   logic [DATA_W-1:0]  result_q;
   logic [3:0]         rd_q;
   logic               wr_en_q;
   logic [FLAGS_W-1:0] flags_q, flags_d;

   logic               accept, consume;
   logic [DATA_W-1:0]  add_x, add_y, logic_res, alu_res;
   logic               add_cin, is_arith, alu_c, alu_v, wr_en_dec;
   logic [DATA_W:0]    sum;
   logic [FLAGS_W-1:0] alu_flags;

   assign in_ready = !flush && (!out_valid_q || out_ready);
   assign accept   = in_valid && in_ready;
   assign consume  = out_valid_q && out_ready;

   // Adder operand selection; subtracts use inverted inputs so C is not-borrow.
   always_comb begin
      add_x    = op_a;
      add_y    = op_b;
      add_cin  = 1'b0;
      is_arith = 1'b1;
      unique case (alu_opcode)
         OpSub, OpCmp: begin add_y = ~op_b; add_cin = 1'b1; end
         OpRsb:        begin add_x = op_b; add_y = ~op_a; add_cin = 1'b1; end
         OpAdd, OpCmn: ;
         OpAdc:        add_cin = flags_q[FlagC];
         OpSbc:        begin add_y = ~op_b; add_cin = flags_q[FlagC]; end
         OpRsc:        begin add_x = op_b; add_y = ~op_a; add_cin = flags_q[FlagC]; end
         default:      is_arith = 1'b0;
      endcase
   end

   assign sum = {1'b0, add_x} + {1'b0, add_y} + {{DATA_W{1'b0}}, add_cin};

   always_comb begin
      logic_res = '0;
      unique case (alu_opcode)
         OpAnd, OpTst: logic_res = op_a & op_b;
         OpEor, OpTeq: logic_res = op_a ^ op_b;
         OpOrr:        logic_res = op_a | op_b;
         OpMov:        logic_res = op_b;
         OpBic:        logic_res = op_a & ~op_b;
         OpMvn:        logic_res = ~op_b;
         default:      logic_res = '0;
      endcase
   end

   assign alu_res = is_arith ? sum[DATA_W-1:0] : logic_res;
   assign alu_c   = is_arith ? sum[DATA_W] : flags_q[FlagC];
   assign alu_v   = is_arith ? ((add_x[DATA_W-1] == add_y[DATA_W-1]) &&
                                (alu_res[DATA_W-1] != add_x[DATA_W-1]))
                             : flags_q[FlagV];
   assign wr_en_dec = !(alu_opcode inside {OpTst, OpTeq, OpCmp, OpCmn});

   always_comb begin
      alu_flags        = flags_q;
      alu_flags[FlagN] = alu_res[DATA_W-1];
      alu_flags[FlagZ] = (alu_res == '0);
      alu_flags[FlagC] = alu_c;
      alu_flags[FlagV] = alu_v;
   end

   // ALU-written bits win over an MSR load landing on the same edge.
   always_comb begin
      flags_d = flags_q;
      for (int i = 0; i < int'(FLAGS_W); i++) begin
         if (accept && should_set_cpsr[i]) begin
            flags_d[i] = alu_flags[i];
         end else if (cpsr_load) begin
            flags_d[i] = cpsr_load_data[i];
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_valid_q <= 1'b0;
         result_q    <= '0;
         rd_q        <= '0;
         wr_en_q     <= 1'b0;
         flags_q     <= '0;
      end else begin
         flags_q <= flags_d;
         if (accept) begin
            out_valid_q <= 1'b1;
            result_q    <= alu_res;
            rd_q        <= rd_in;
            wr_en_q     <= wr_en_dec;
         end else if (flush || consume) begin
            out_valid_q <= 1'b0;
         end
      end
   end

   assign out_valid = out_valid_q;
   assign result    = result_q;
   assign rd_out    = rd_q;
   assign rd_wr_en  = wr_en_q;
   assign flags     = flags_q;

endmodule

// File: tb/tb_alu_exec.sv
// Bench for alu_exec: directed vectors, an arithmetic-level reference model
// compared every cycle, and literal expectations at key points.
module tb_alu_exec;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid, in_ready;
   logic [3:0]  alu_opcode, should_set_cpsr, cpsr_load_data, rd_in, rd_out, flags;
   logic [31:0] op_a, op_b, result;
   logic        flush, cpsr_load, out_valid, out_ready, rd_wr_en;

   int checks = 0;
   int errors = 0;

   alu_exec dut (
      .clk            (clk),
      .reset          (reset),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .alu_opcode     (alu_opcode),
      .should_set_cpsr(should_set_cpsr),
      .op_a           (op_a),
      .op_b           (op_b),
      .rd_in          (rd_in),
      .flush          (flush),
      .cpsr_load      (cpsr_load),
      .cpsr_load_data (cpsr_load_data),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .result         (result),
      .rd_out         (rd_out),
      .rd_wr_en       (rd_wr_en),
      .flags          (flags)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Returns {nzcv, result} from plain signed/unsigned arithmetic.
   function automatic logic [35:0] model_op(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic [3:0] f);
      longint unsigned ua, ub, u;
      longint sa, sb, s, ci;
      logic [31:0] r;
      logic cc, vv, arith;
      ua = {32'd0, a};
      ub = {32'd0, b};
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ci = f[1] ? 1 : 0;
      cc = f[1];
      vv = f[0];
      s = 0;
      arith = 1'b1;
      case (op)
         4'h2, 4'hA: begin r = a - b; cc = (ua >= ub); s = sa - sb; end
         4'h3:       begin r = b - a; cc = (ub >= ua); s = sb - sa; end
         4'h4, 4'hB: begin u = ua + ub; r = u[31:0]; cc = u[32]; s = sa + sb; end
         4'h5:       begin u = ua + ub + ci; r = u[31:0]; cc = u[32]; s = sa + sb + ci; end
         4'h6:       begin u = ua - ub - (1 - ci); r = u[31:0]; cc = (ua >= ub + 1 - ci);
                           s = sa - sb - (1 - ci); end
         4'h7:       begin u = ub - ua - (1 - ci); r = u[31:0]; cc = (ub >= ua + 1 - ci);
                           s = sb - sa - (1 - ci); end
         4'h0, 4'h8: begin r = a & b; arith = 1'b0; end
         4'h1, 4'h9: begin r = a ^ b; arith = 1'b0; end
         4'hC:       begin r = a | b; arith = 1'b0; end
         4'hD:       begin r = b; arith = 1'b0; end
         4'hE:       begin r = a & ~b; arith = 1'b0; end
         default:    begin r = ~b; arith = 1'b0; end
      endcase
      if (arith) vv = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      return {r[31], (r == 32'd0), cc, vv, r};
   endfunction

   // Reference state, advanced on the same edges as the DUT.
   logic        m_valid, m_wr;
   logic [31:0] m_result;
   logic [3:0]  m_rd, m_flags, m_next_flags;
   logic [35:0] m_calc;
   logic        m_ready, m_accept;

   assign m_ready  = !flush && (!m_valid || out_ready);
   assign m_accept = in_valid && m_ready;
   assign m_calc   = model_op(alu_opcode, op_a, op_b, m_flags);

   always_comb begin
      m_next_flags = m_flags;
      for (int i = 0; i < 4; i++) begin
         if (m_accept && should_set_cpsr[i]) m_next_flags[i] = m_calc[32 + i];
         else if (cpsr_load) m_next_flags[i] = cpsr_load_data[i];
      end
   end

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_valid  <= 1'b0;
         m_result <= '0;
         m_rd     <= '0;
         m_wr     <= 1'b0;
         m_flags  <= '0;
      end else begin
         m_flags <= m_next_flags;
         if (m_accept) begin
            m_valid  <= 1'b1;
            m_result <= m_calc[31:0];
            m_rd     <= rd_in;
            m_wr     <= !(alu_opcode inside {4'h8, 4'h9, 4'hA, 4'hB});
         end else if (flush || (m_valid && out_ready)) begin
            m_valid <= 1'b0;
         end
      end
   end

   always @(negedge clk) begin
      if (!reset) begin
         check("in_ready", {31'd0, in_ready}, {31'd0, m_ready});
         check("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
         check("flags", {28'd0, flags}, {28'd0, m_flags});
         if (m_valid) begin
            check("result", result, m_result);
            check("rd_out", {28'd0, rd_out}, {28'd0, m_rd});
            check("rd_wr_en", {31'd0, rd_wr_en}, {31'd0, m_wr});
         end
      end
   end

   task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] mask, input logic [3:0] rd);
      in_valid        = 1'b1;
      alu_opcode      = op;
      op_a            = a;
      op_b            = b;
      should_set_cpsr = mask;
      rd_in           = rd;
   endtask

   task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] mask, input logic [3:0] rd);
      drive(op, a, b, mask, rd);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   logic [31:0] pa [4] = '{32'd5, 32'd3, 32'h8000_0000, 32'h7FFF_FFFF};
   logic [31:0] pb [4] = '{32'd3, 32'd5, 32'd1, 32'hFFFF_FFFF};

   initial begin
      reset = 1'b1; in_valid = 1'b0; alu_opcode = '0; should_set_cpsr = '0;
      op_a = '0; op_b = '0; rd_in = '0; flush = 1'b0; cpsr_load = 1'b0;
      cpsr_load_data = '0; out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_flags", {28'd0, flags}, 32'd0);
      reset = 1'b0;
      @(posedge clk); #1;

      issue(4'h2, 32'd5, 32'd5, 4'hF, 4'd3);
      check("sub_result", result, 32'd0);
      check("sub_flags", {28'd0, flags}, 32'b0110);
      issue(4'hA, 32'd0, 32'd1, 4'hF, 4'd4);
      check("cmp_flags", {28'd0, flags}, 32'b1000);
      check("cmp_wr_en", {31'd0, rd_wr_en}, 32'd0);
      issue(4'h4, 32'h7FFF_FFFF, 32'd1, 4'hF, 4'd1);
      check("add_ovf_result", result, 32'h8000_0000);
      check("add_ovf_flags", {28'd0, flags}, 32'b1001);
      issue(4'h4, 32'h7FFF_FFFF, 32'd1, 4'h0, 4'd1);
      check("mask0_flags", {28'd0, flags}, 32'b1001);
      issue(4'h4, 32'hFFFF_FFFF, 32'd1, 4'hF, 4'd2);
      check("add_carry_flags", {28'd0, flags}, 32'b0110);
      issue(4'h5, 32'd0, 32'd0, 4'hF, 4'd2);
      check("adc_chain_result", result, 32'd1);

      // Hold writeback off with a new op waiting.
      out_ready = 1'b0;
      drive(4'h4, 32'd10, 32'd20, 4'h0, 4'd5);
      repeat (3) begin
         @(posedge clk); #1;
         check("bp_in_ready", {31'd0, in_ready}, 32'd0);
         check("bp_held", result, 32'd1);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      check("bp_release_valid", {31'd0, out_valid}, 32'd1);
      check("bp_release_result", result, 32'd30);
      issue(4'h1, 32'hFF00_FF00, 32'h0F0F_0F0F, 4'h0, 4'd6);
      check("swap_result", result, 32'hF00F_F00F);
      @(posedge clk); #1;
      check("drain_valid", {31'd0, out_valid}, 32'd0);

      for (int op = 0; op < 16; op++) begin
         for (int p = 0; p < 4; p++) issue(4'(op), pa[p], pb[p], 4'hF, 4'(op));
      end

      cpsr_load = 1'b1; cpsr_load_data = 4'b0101;
      issue(4'h0, 32'hF0, 32'h0F, 4'b1100, 4'd7);
      cpsr_load = 1'b0;
      check("collide_flags", {28'd0, flags}, 32'b0101);
      check("collide_result", result, 32'd0);

      flush = 1'b1;
      drive(4'hD, 32'd0, 32'd123, 4'hF, 4'd8);
      #1;
      check("flush_in_ready", {31'd0, in_ready}, 32'd0);
      @(posedge clk); #1;
      flush = 1'b0; in_valid = 1'b0;
      check("flush_valid", {31'd0, out_valid}, 32'd0);
      check("flush_flags", {28'd0, flags}, 32'b0101);

      cpsr_load = 1'b1; cpsr_load_data = 4'hF;
      issue(4'hD, 32'd0, 32'd99, 4'h0, 4'd9);
      cpsr_load = 1'b0;
      check("pre_rst_flags", {28'd0, flags}, 32'hF);
      check("pre_rst_valid", {31'd0, out_valid}, 32'd1);
      #2 reset = 1'b1;
      #1;
      check("async_rst_valid", {31'd0, out_valid}, 32'd0);
      check("async_rst_flags", {28'd0, flags}, 32'd0);
      check("async_rst_result", result, 32'd0);
      repeat (2) @(posedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
